data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Responder side of the CPU data-memory interface: services CPU load/store requests
//   (addr/wdata/write/memsize) with a word-organised RAM and a small MMIO page.
//   The MMIO page holds a console TX FIFO, a status register and a 64-bit cycle counter.
//   Single-cycle core: read data is combinational; all state updates on i_clk.
// PARAMETERS
//   DEPTH_WORDS  4096            RAM size in 32-bit words (power of 2)
//   FIFO_DEPTH   16              console TX FIFO entries (power of 2, >=2)
//   MMIO_BASE    32'hFFFF_0000   base of 16-byte MMIO page; addr >= MMIO_BASE selects MMIO
// PORTS
//   i_clk        in   1   clock, all state on rising edge
//   i_reset      in   1   synchronous, active-high reset
//   i_write      in   1   store request this cycle
//   i_addr       in   32  byte address (CPU ALU result)
//   i_data       in   32  store data; valid bytes in low lanes
//   i_memsize    in   2   01 byte, 10 half, 11 word, 00 no access
//   o_data       out  32  load data, addressed byte/half in bits [7:0]/[15:0]
//   o_tx_valid   out  1   console FIFO non-empty
//   o_tx_data    out  8   FIFO head byte
//   i_tx_ready   in   1   sink accepts head when o_tx_valid & i_tx_ready
//   o_misaligned out  1   sticky: a misaligned store was dropped
// BEHAVIOUR
// - Reset: FIFO empty (o_tx_valid=0, o_tx_data=0), overflow=0, o_misaligned=0, counter=0.
//   RAM contents are NOT cleared by reset.
// - RAM index = i_addr[log2(DEPTH_WORDS)+1:2]; upper bits ignored below MMIO_BASE (alias/wrap).
// - Read (combinational, every cycle, no strobe):
//   o_data = selected_word >> (8*i_addr[1:0]).
//   The CPU does sign/zero extension.
// - Store (i_write=1, i_memsize!=00), committed at the clock edge:
//   - byte: lane i_addr[1:0] <= i_data[7:0].
//   - half: lanes {a+1,a} <= i_data[15:0]; requires i_addr[0]=0.
//   - word: all lanes; requires i_addr[1:0]=00.
//   - Misaligned: write suppressed, o_misaligned set next cycle, held until reset.
//   - i_memsize=00 with i_write=1: no effect.
// - MMIO page (offset = i_addr[3:2]):
//   - 0 TXDATA: write pushes i_data[7:0] for any size; reads 0.
//   - 1 STATUS: read {overflow[31], full[30], empty[29], 0, count[7:0]}.
//     A write with i_data[31]=1 clears overflow.
//   - 2 CYCLE_LO: read counter[31:0], writes ignored.
//   - 3 CYCLE_HI: read counter[63:32], writes ignored.
//     Software reads HI, LO, HI and retries on mismatch.
// - Cycle counter: +1 every cycle after reset, wraps 2^64-1 -> 0.
// - FIFO:
//   - pop = o_tx_valid & i_tx_ready.
//   - push is accepted if !full | pop.
//   - push & pop in the same cycle: count unchanged, head advances.
//   - Push when full without pop: byte dropped, overflow set.
//   - Pointers wrap mod FIFO_DEPTH.
//   - o_tx_data is the registered head, valid the cycle after the push lands in an empty FIFO.
//   - count is 0..FIFO_DEPTH.
// - Reset mid-operation: pending FIFO bytes are discarded.
//   A store in the reset cycle is ignored for MMIO state; RAM behaviour is don't-care.
// TESTING
// - sw 0x11223344 @0x100, then lb @0x101 / lh @0x102 -> o_data[7:0]=0x33, o_data[15:0]=0x1122.
// - sb 0xAA @0x103 over 0x11223344 -> word reads 0xAA223344.
//   sh @0x101 -> word unchanged, o_misaligned=1.
// - Push 'H','i' with i_tx_ready=0 -> STATUS count=2, o_tx_data=0x48.
//   Assert ready 2 cycles -> 0x48 then 0x69, empty=1.
// - Fill 16 bytes, push a 17th -> dropped, overflow=1, full=1.
//   Push+pop on the same cycle while full -> count stays 16.
//   Write STATUS 0x8000_0000 -> overflow=0.
// - Release reset, wait 10 cycles -> CYCLE_LO=10.
//   Force the counter to 0xFFFF_FFFF low -> HI increments on the next cycle.
// - Assert i_reset mid-drain with 5 bytes queued -> next cycle o_tx_valid=0, count=0, counter=0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus between the core (master) and the memory/MMIO responder (slave).
// The console TX sink handshake travels on the same bundle.
interface data_mem_responder_if;
    logic        i_write;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [1:0]  i_memsize;
    logic [31:0] o_data;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready;
    logic        o_misaligned;

    modport slave (
        input  i_write, i_addr, i_data, i_memsize, i_tx_ready,
        output o_data, o_tx_valid, o_tx_data, o_misaligned
    );

    modport master (
        output i_write, i_addr, i_data, i_memsize, i_tx_ready,
        input  o_data, o_tx_valid, o_tx_data, o_misaligned
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-organised RAM with byte/half/word stores, plus an MMIO page
// holding a console TX FIFO, a status register and a free-running 64-bit cycle counter.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    data_mem_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_txData;
    logic          r_overflow;
    logic          r_misaligned;
    logic [63:0]   r_cycle;

    logic          w_mmioSel;
    logic [1:0]    w_offset;
    logic          w_store;
    logic          w_misalign;
    logic          w_storeOk;
    logic [AW-1:0] w_ramIdx;
    logic [3:0]    w_byteEn;
    logic [31:0]   w_wdataLane;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_pushReq;
    logic          w_push;
    logic [PW-1:0] w_rptrNext;
    logic [7:0]    w_count8;
    logic [31:0]   w_mmioWord;
    logic [31:0]   w_word;

    assign w_mmioSel   = (bus.i_addr >= MMIO_BASE);
    assign w_offset    = bus.i_addr[3:2];
    assign w_store     = bus.i_write & (bus.i_memsize != 2'b00);
    assign w_misalign  = ((bus.i_memsize == 2'b10) & bus.i_addr[0]) |
                         ((bus.i_memsize == 2'b11) & (bus.i_addr[1:0] != 2'b00));
    assign w_storeOk   = w_store & ~w_misalign;
    assign w_ramIdx    = bus.i_addr[AW+1:2];
    assign w_wdataLane = bus.i_data << {bus.i_addr[1:0], 3'b000};

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_pop      = ~w_empty & bus.i_tx_ready;
    // A store landing in the reset cycle must not disturb the freshly cleared FIFO.
    assign w_pushReq  = w_storeOk & w_mmioSel & (w_offset == 2'd0) & ~i_reset;
    assign w_push     = w_pushReq & (~w_full | w_pop);
    assign w_rptrNext = r_rptr + 1'b1;
    assign w_count8   = 8'(r_count);

    always_comb begin
        w_byteEn = 4'b0000;
        case (bus.i_memsize)
            2'b01:   w_byteEn = 4'b0001 << bus.i_addr[1:0];
            2'b10:   w_byteEn = 4'b0011 << bus.i_addr[1:0];
            2'b11:   w_byteEn = 4'b1111;
            default: w_byteEn = 4'b0000;
        endcase
    end

    always_comb begin
        w_mmioWord = 32'h0;
        case (w_offset)
            2'd1:    w_mmioWord = {r_overflow, w_full, w_empty, 21'h0, w_count8};
            2'd2:    w_mmioWord = r_cycle[31:0];
            2'd3:    w_mmioWord = r_cycle[63:32];
            default: w_mmioWord = 32'h0;
        endcase
    end

    assign w_word           = w_mmioSel ? w_mmioWord : r_mem[w_ramIdx];
    assign bus.o_data       = w_word >> {bus.i_addr[1:0], 3'b000};
    assign bus.o_tx_valid   = ~w_empty;
    assign bus.o_tx_data    = r_txData;
    assign bus.o_misaligned = r_misaligned;

    always_ff @(posedge i_clk) begin
        if (w_storeOk && !w_mmioSel) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) r_mem[w_ramIdx][8*b +: 8] <= w_wdataLane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wptr] <= bus.i_data[7:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_txData     <= 8'h00;
            r_overflow   <= 1'b0;
            r_misaligned <= 1'b0;
            r_cycle      <= 64'h0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_store && w_misalign) r_misaligned <= 1'b1;
            if (w_pushReq && !w_push) begin
                r_overflow <= 1'b1;
            end else if (w_storeOk && w_mmioSel && (w_offset == 2'd1) && bus.i_data[31]) begin
                r_overflow <= 1'b0;
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= w_rptrNext;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // The head register is preloaded so o_tx_data is valid alongside o_tx_valid.
            if (w_pop) begin
                if (r_count > CW'(1))  r_txData <= r_fifo[w_rptrNext];
                else if (w_push)       r_txData <= bus.i_data[7:0];
                else                   r_txData <= 8'h00;
            end else if (w_push && w_empty) begin
                r_txData <= bus.i_data[7:0];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: RAM load/store, misalignment, console FIFO
// (scoreboarded), overflow, cycle counter and reset behaviour.
module tb_data_mem_responder;
    localparam logic [31:0] MMIO = 32'hFFFF_0000;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;
    logic [7:0]  txq [$];
    logic [31:0] rd;

    data_mem_responder_if bus();

    data_mem_responder #(
        .DEPTH_WORDS (4096),
        .FIFO_DEPTH  (16),
        .MMIO_BASE   (MMIO)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "[TB] timeout");
    end

    // Drive one store for exactly one rising edge; returns just after the following falling edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        @(negedge clk);
        bus.i_addr    = a;
        bus.i_data    = d;
        bus.i_memsize = sz;
        bus.i_write   = 1'b1;
        @(negedge clk);
        bus.i_write   = 1'b0;
        bus.i_memsize = 2'b00;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, output logic [31:0] d);
        bus.i_write   = 1'b0;
        bus.i_addr    = a;
        bus.i_memsize = sz;
        #1;
        d = bus.o_data;
    endtask

    task automatic pushByte(input logic [7:0] b);
        store(MMIO, {24'h0, b}, 2'b01);
        txq.push_back(b);
    endtask

    // Pops n bytes from the DUT, each compared with the scoreboard head; bounded by n cycles.
    task automatic drain(input int n);
        logic [7:0] exp;
        bus.i_tx_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            testsRun++;
            if (bus.o_tx_valid !== 1'b1 || txq.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL drain_valid: o_tx_valid=%0b queued=%0d, required valid=1 with a byte queued",
                         bus.o_tx_valid, txq.size());
            end else begin
                exp = txq.pop_front();
                if (bus.o_tx_data !== exp) begin
                    testsFailed++;
                    $display("[TB] FAIL drain_data: got %h, required %h", bus.o_tx_data, exp);
                end
            end
            @(negedge clk);
        end
        bus.i_tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        testsRun++; if (bus.o_tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %0b, required 0", bus.o_tx_valid); end
        testsRun++; if (bus.o_tx_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_txdata: got %h, required 00", bus.o_tx_data); end
        testsRun++; if (bus.o_misaligned !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_misaligned: got %0b, required 0", bus.o_misaligned); end
        load(MMIO + 32'h4, 2'b11, rd);
        testsRun++; if (rd !== 32'h2000_0000) begin testsFailed++; $display("[TB] FAIL reset_status: got %h, required 20000000", rd); end
        load(MMIO + 32'h8, 2'b11, rd);
        testsRun++; if (rd !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_cycle: got %h, required 00000000", rd); end
    endtask

    task automatic test_cycle_counter();
        reset = 1'b0;
        repeat (10) @(negedge clk);
        load(MMIO + 32'h8, 2'b11, rd);
        testsRun++; if (rd !== 32'd10) begin testsFailed++; $display("[TB] FAIL cycle_lo_10: got %0d, required 10", rd); end
        load(MMIO + 32'hC, 2'b11, rd);
        testsRun++; if (rd !== 32'd0) begin testsFailed++; $display("[TB] FAIL cycle_hi_0: got %h, required 0", rd); end
        @(negedge clk);
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.r_cycle;
        load(MMIO + 32'h8, 2'b11, rd);
        testsRun++; if (rd !== 32'hFFFF_FFFF) begin testsFailed++; $display("[TB] FAIL cycle_lo_forced: got %h, required ffffffff", rd); end
        @(negedge clk);
        load(MMIO + 32'hC, 2'b11, rd);
        testsRun++; if (rd !== 32'd1) begin testsFailed++; $display("[TB] FAIL cycle_hi_carry: got %h, required 00000001", rd); end
        load(MMIO + 32'h8, 2'b11, rd);
        testsRun++; if (rd !== 32'd0) begin testsFailed++; $display("[TB] FAIL cycle_lo_wrap: got %h, required 00000000", rd); end
    endtask

    task automatic test_ram();
        store(32'h100, 32'h1122_3344, 2'b11);
        load(32'h100, 2'b11, rd);
        testsRun++; if (rd !== 32'h1122_3344) begin testsFailed++; $display("[TB] FAIL lw: got %h, required 11223344", rd); end
        load(32'h101, 2'b01, rd);
        testsRun++; if (rd[7:0] !== 8'h33) begin testsFailed++; $display("[TB] FAIL lb_101: got %h, required 33", rd[7:0]); end
        load(32'h102, 2'b10, rd);
        testsRun++; if (rd[15:0] !== 16'h1122) begin testsFailed++; $display("[TB] FAIL lh_102: got %h, required 1122", rd[15:0]); end
        load(32'h4100, 2'b11, rd);
        testsRun++; if (rd !== 32'h1122_3344) begin testsFailed++; $display("[TB] FAIL alias_wrap: got %h, required 11223344", rd); end
        store(32'h103, 32'h0000_00AA, 2'b01);
        load(32'h100, 2'b11, rd);
        testsRun++; if (rd !== 32'hAA22_3344) begin testsFailed++; $display("[TB] FAIL sb_103: got %h, required aa223344", rd); end
        testsRun++; if (bus.o_misaligned !== 1'b0) begin testsFailed++; $display("[TB] FAIL misaligned_early: got %0b, required 0", bus.o_misaligned); end
        store(32'h101, 32'h0000_5555, 2'b10);
        load(32'h100, 2'b11, rd);
        testsRun++; if (rd !== 32'hAA22_3344) begin testsFailed++; $display("[TB] FAIL sh_misaligned_data: got %h, required aa223344", rd); end
        testsRun++; if (bus.o_misaligned !== 1'b1) begin testsFailed++; $display("[TB] FAIL sh_misaligned_flag: got %0b, required 1", bus.o_misaligned); end
        store(32'h102, 32'h0000_BEEF, 2'b10);
        load(32'h100, 2'b11, rd);
        testsRun++; if (rd !== 32'hBEEF_3344) begin testsFailed++; $display("[TB] FAIL sh_102: got %h, required beef3344", rd); end
        store(32'h100, 32'hDEAD_0000, 2'b00);
        load(32'h100, 2'b11, rd);
        testsRun++; if (rd !== 32'hBEEF_3344) begin testsFailed++; $display("[TB] FAIL size00_noop: got %h, required beef3344", rd); end
        testsRun++; if (bus.o_misaligned !== 1'b1) begin testsFailed++; $display("[TB] FAIL misaligned_sticky: got %0b, required 1", bus.o_misaligned); end
    endtask

    task automatic test_tx_basic();
        bus.i_tx_ready = 1'b0;
        pushByte(8'h48);
        pushByte(8'h69);
        load(MMIO + 32'h4, 2'b11, rd);
        testsRun++; if (rd !== 32'h0000_0002) begin testsFailed++; $display("[TB] FAIL tx_status_2: got %h, required 00000002", rd); end
        testsRun++; if (bus.o_tx_data !== 8'h48) begin testsFailed++; $display("[TB] FAIL tx_head: got %h, required 48", bus.o_tx_data); end
        load(MMIO, 2'b11, rd);
        testsRun++; if (rd !== 32'h0) begin testsFailed++; $display("[TB] FAIL txdata_read: got %h, required 00000000", rd); end
        drain(2);
        load(MMIO + 32'h4, 2'b11, rd);
        testsRun++; if (rd !== 32'h2000_0000) begin testsFailed++; $display("[TB] FAIL tx_empty: got %h, required 20000000", rd); end
        testsRun++; if (bus.o_tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL tx_valid_after: got %0b, required 0", bus.o_tx_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) pushByte(8'h10 + 8'(i));
        load(MMIO + 32'h4, 2'b11, rd);
        testsRun++; if (rd !== 32'h4000_0010) begin testsFailed++; $display("[TB] FAIL full_status: got %h, required 40000010", rd); end
        store(MMIO, 32'h0000_00EE, 2'b01);
        load(MMIO + 32'h4, 2'b11, rd);
        testsRun++; if (rd !== 32'hC000_0010) begin testsFailed++; $display("[TB] FAIL overflow_status: got %h, required c0000010", rd); end
        @(negedge clk);
        bus.i_addr = MMIO; bus.i_data = 32'h0000_0077; bus.i_memsize = 2'b01; bus.i_write = 1'b1;
        bus.i_tx_ready = 1'b1;
        #1;
        exp = txq.pop_front();
        txq.push_back(8'h77);
        testsRun++; if (bus.o_tx_data !== exp) begin testsFailed++; $display("[TB] FAIL pushpop_head: got %h, required %h", bus.o_tx_data, exp); end
        @(negedge clk);
        bus.i_write = 1'b0; bus.i_memsize = 2'b00; bus.i_tx_ready = 1'b0;
        load(MMIO + 32'h4, 2'b11, rd);
        testsRun++; if (rd !== 32'hC000_0010) begin testsFailed++; $display("[TB] FAIL pushpop_count: got %h, required c0000010", rd); end
        store(MMIO + 32'h4, 32'h8000_0000, 2'b11);
        load(MMIO + 32'h4, 2'b11, rd);
        testsRun++; if (rd !== 32'h4000_0010) begin testsFailed++; $display("[TB] FAIL overflow_clear: got %h, required 40000010", rd); end
        drain(16);
        load(MMIO + 32'h4, 2'b11, rd);
        testsRun++; if (rd !== 32'h2000_0000) begin testsFailed++; $display("[TB] FAIL drained_status: got %h, required 20000000", rd); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 5; i++) pushByte(8'hA0 + 8'(i));
        drain(2);
        bus.i_tx_ready = 1'b1;
        reset = 1'b1;
        bus.i_addr = MMIO; bus.i_data = 32'h0000_0051; bus.i_memsize = 2'b01; bus.i_write = 1'b1;
        @(negedge clk);
        bus.i_write = 1'b0; bus.i_memsize = 2'b00;
        #1;
        txq.delete();
        testsRun++; if (bus.o_tx_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_valid: got %0b, required 0", bus.o_tx_valid); end
        load(MMIO + 32'h4, 2'b11, rd);
        testsRun++; if (rd !== 32'h2000_0000) begin testsFailed++; $display("[TB] FAIL midreset_status: got %h, required 20000000", rd); end
        load(MMIO + 32'h8, 2'b11, rd);
        testsRun++; if (rd !== 32'h0) begin testsFailed++; $display("[TB] FAIL midreset_cycle: got %h, required 00000000", rd); end
        testsRun++; if (bus.o_misaligned !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_misaligned: got %0b, required 0", bus.o_misaligned); end
        reset = 1'b0;
        bus.i_tx_ready = 1'b0;
        pushByte(8'h5A);
        #1;
        testsRun++; if (bus.o_tx_data !== 8'h5A) begin testsFailed++; $display("[TB] FAIL after_reset_push: got %h, required 5a", bus.o_tx_data); end
        drain(1);
    endtask

    initial begin
        testsRun       = 0;
        testsFailed    = 0;
        reset          = 1'b1;
        bus.i_write    = 1'b0;
        bus.i_addr     = 32'h0;
        bus.i_data     = 32'h0;
        bus.i_memsize  = 2'b00;
        bus.i_tx_ready = 1'b0;
        test_reset();
        test_cycle_counter();
        test_ram();
        test_tx_basic();
        test_overflow();
        test_reset_mid_drain();
        testsRun++;
        if (txq.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_leftover: %0d bytes still expected, required 0", txq.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
